// File: rtl/wb_register_file.sv
// Write-back register file: commits the EX/WB triple into 2**REG_NUM_WIDTH registers,
// serves bypassed ID reads and EX operand forwarding, and counts commits.
module wb_register_file #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned REG_NUM_WIDTH = 3,
   parameter int unsigned COUNT_WIDTH   = 16
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     EX_WB_RegWrite,
   input  logic [DATA_WIDTH-1:0]    EX_WB_Write_Data,
   input  logic [REG_NUM_WIDTH-1:0] EX_WB_Write_Reg_Num,
   input  logic [REG_NUM_WIDTH-1:0] Read_Reg_Num1,
   input  logic [REG_NUM_WIDTH-1:0] Read_Reg_Num2,
   output logic [DATA_WIDTH-1:0]    Read_Data1,
   output logic [DATA_WIDTH-1:0]    Read_Data2,
   input  logic [REG_NUM_WIDTH-1:0] ID_EX_Src1_Num,
   input  logic [REG_NUM_WIDTH-1:0] ID_EX_Src2_Num,
   input  logic [DATA_WIDTH-1:0]    ID_EX_Src1_Data,
   input  logic [DATA_WIDTH-1:0]    ID_EX_Src2_Data,
   output logic [DATA_WIDTH-1:0]    Fwd_Data1,
   output logic [DATA_WIDTH-1:0]    Fwd_Data2,
   output logic                     Fwd_Sel1,
   output logic                     Fwd_Sel2,
   output logic [COUNT_WIDTH-1:0]   Commit_Count
);

   localparam int unsigned NUM_REGS = 1 << REG_NUM_WIDTH;

   logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
   logic [COUNT_WIDTH-1:0] count_q;
   logic [COUNT_WIDTH-1:0] count_d;

   assign count_d = count_q + 1'b1;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         regs_q  <= '{default: '0};
         count_q <= '0;
      end else if (EX_WB_RegWrite) begin
         regs_q[EX_WB_Write_Reg_Num] <= EX_WB_Write_Data;
         count_q                     <= count_d;
      end
   end

   // Reset gates the combinational paths too, so nothing leaks out while state is held clear.
   always_comb begin
      Read_Data1 = '0;
      Read_Data2 = '0;
      Fwd_Sel1   = 1'b0;
      Fwd_Sel2   = 1'b0;
      if (Reset) begin
         Read_Data1 = (EX_WB_RegWrite && (EX_WB_Write_Reg_Num == Read_Reg_Num1))
                      ? EX_WB_Write_Data : regs_q[Read_Reg_Num1];
         Read_Data2 = (EX_WB_RegWrite && (EX_WB_Write_Reg_Num == Read_Reg_Num2))
                      ? EX_WB_Write_Data : regs_q[Read_Reg_Num2];
         Fwd_Sel1   = EX_WB_RegWrite && (EX_WB_Write_Reg_Num == ID_EX_Src1_Num);
         Fwd_Sel2   = EX_WB_RegWrite && (EX_WB_Write_Reg_Num == ID_EX_Src2_Num);
      end
      Fwd_Data1 = Fwd_Sel1 ? EX_WB_Write_Data : ID_EX_Src1_Data;
      Fwd_Data2 = Fwd_Sel2 ? EX_WB_Write_Data : ID_EX_Src2_Data;
   end

   assign Commit_Count = count_q;

endmodule

// File: tb/tb_wb_register_file.sv
// Directed bench for wb_register_file: reset, write/read, bypass, forwarding and counter wrap.
module tb_wb_register_file;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        EX_WB_RegWrite;
   logic [7:0]  EX_WB_Write_Data;
   logic [2:0]  EX_WB_Write_Reg_Num;
   logic [2:0]  Read_Reg_Num1, Read_Reg_Num2;
   logic [7:0]  Read_Data1, Read_Data2;
   logic [2:0]  ID_EX_Src1_Num, ID_EX_Src2_Num;
   logic [7:0]  ID_EX_Src1_Data, ID_EX_Src2_Data;
   logic [7:0]  Fwd_Data1, Fwd_Data2;
   logic        Fwd_Sel1, Fwd_Sel2;
   logic [15:0] Commit_Count;

   int tests  = 0;
   int failed = 0;

   always #5 Clk = ~Clk;

   wb_register_file #(
      .DATA_WIDTH   (8),
      .REG_NUM_WIDTH(3),
      .COUNT_WIDTH  (16)
   ) dut (
      .Clk                (Clk),
      .Reset              (Reset),
      .EX_WB_RegWrite     (EX_WB_RegWrite),
      .EX_WB_Write_Data   (EX_WB_Write_Data),
      .EX_WB_Write_Reg_Num(EX_WB_Write_Reg_Num),
      .Read_Reg_Num1      (Read_Reg_Num1),
      .Read_Reg_Num2      (Read_Reg_Num2),
      .Read_Data1         (Read_Data1),
      .Read_Data2         (Read_Data2),
      .ID_EX_Src1_Num     (ID_EX_Src1_Num),
      .ID_EX_Src2_Num     (ID_EX_Src2_Num),
      .ID_EX_Src1_Data    (ID_EX_Src1_Data),
      .ID_EX_Src2_Data    (ID_EX_Src2_Data),
      .Fwd_Data1          (Fwd_Data1),
      .Fwd_Data2          (Fwd_Data2),
      .Fwd_Sel1           (Fwd_Sel1),
      .Fwd_Sel2           (Fwd_Sel2),
      .Commit_Count       (Commit_Count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      Reset = 1'b1;
      EX_WB_RegWrite = 1'b0; EX_WB_Write_Data = '0; EX_WB_Write_Reg_Num = '0;
      Read_Reg_Num1 = '0; Read_Reg_Num2 = '0;
      ID_EX_Src1_Num = '0; ID_EX_Src2_Num = '0;
      ID_EX_Src1_Data = '0; ID_EX_Src2_Data = '0;
      #2 Reset = 1'b0;
      #1;
      check("reset_count", Commit_Count, 16'h0000);
      check("reset_rd1", Read_Data1, 8'h00);

      // gating while held in reset
      EX_WB_RegWrite = 1'b1; EX_WB_Write_Reg_Num = 3'd3; EX_WB_Write_Data = 8'hEE;
      Read_Reg_Num1 = 3'd3; ID_EX_Src1_Num = 3'd3; ID_EX_Src1_Data = 8'h5A;
      #1;
      check("rst_gate_rd1", Read_Data1, 8'h00);
      check("rst_gate_sel1", Fwd_Sel1, 1'b0);
      check("rst_gate_fwd1", Fwd_Data1, 8'h5A);
      @(posedge Clk); #1;
      check("rst_block_cnt", Commit_Count, 16'h0000);

      // release, then write r3=A5
      @(negedge Clk);
      EX_WB_RegWrite = 1'b0;
      Reset = 1'b1;
      @(negedge Clk);
      EX_WB_RegWrite = 1'b1; EX_WB_Write_Reg_Num = 3'd3; EX_WB_Write_Data = 8'hA5;
      @(posedge Clk); #1;
      EX_WB_RegWrite = 1'b0; Read_Reg_Num1 = 3'd3;
      #1;
      check("r3_loaded", Read_Data1, 8'hA5);
      check("cnt_after_r3", Commit_Count, 16'h0001);

      // asynchronous mid-cycle reset
      Reset = 1'b0;
      #1;
      check("async_rst_rd1", Read_Data1, 8'h00);
      check("async_rst_cnt", Commit_Count, 16'h0000);
      EX_WB_RegWrite = 1'b1; EX_WB_Write_Reg_Num = 3'd3; EX_WB_Write_Data = 8'hFF;
      @(posedge Clk); #1;
      check("rst_discard_cnt", Commit_Count, 16'h0000);
      @(negedge Clk);
      EX_WB_RegWrite = 1'b0; Reset = 1'b1;
      #1;
      check("r3_cleared", Read_Data1, 8'h00);

      // write r5=3C
      @(negedge Clk);
      EX_WB_RegWrite = 1'b1; EX_WB_Write_Reg_Num = 3'd5; EX_WB_Write_Data = 8'h3C;
      @(posedge Clk);
      @(negedge Clk);
      EX_WB_RegWrite = 1'b0; Read_Reg_Num1 = 3'd5;
      #1;
      check("r5_read", Read_Data1, 8'h3C);
      check("cnt_r5", Commit_Count, 16'h0001);

      // r2=11, then same-cycle bypass of r2=77 on both ports
      @(negedge Clk);
      EX_WB_RegWrite = 1'b1; EX_WB_Write_Reg_Num = 3'd2; EX_WB_Write_Data = 8'h11;
      @(posedge Clk);
      @(negedge Clk);
      EX_WB_Write_Data = 8'h77; Read_Reg_Num1 = 3'd2; Read_Reg_Num2 = 3'd2;
      #1;
      check("bypass_rd1", Read_Data1, 8'h77);
      check("bypass_rd2", Read_Data2, 8'h77);
      EX_WB_RegWrite = 1'b0;
      #1;
      check("r2_old_rd1", Read_Data1, 8'h11);
      check("r2_old_rd2", Read_Data2, 8'h11);
      EX_WB_RegWrite = 1'b1;
      @(posedge Clk); #1;
      EX_WB_RegWrite = 1'b0;
      #1;
      check("r2_new_rd1", Read_Data1, 8'h77);
      check("cnt_bypass", Commit_Count, 16'h0003);
      Read_Reg_Num2 = 3'd5;
      #1;
      check("rd2_indep", Read_Data2, 8'h3C);

      // forwarding, not committed
      @(negedge Clk);
      EX_WB_RegWrite = 1'b1; EX_WB_Write_Reg_Num = 3'd4; EX_WB_Write_Data = 8'h9E;
      ID_EX_Src1_Num = 3'd4; ID_EX_Src1_Data = 8'h01;
      ID_EX_Src2_Num = 3'd6; ID_EX_Src2_Data = 8'h42;
      #1;
      check("fwd_sel1", Fwd_Sel1, 1'b1);
      check("fwd_data1", Fwd_Data1, 8'h9E);
      check("fwd_sel2", Fwd_Sel2, 1'b0);
      check("fwd_data2", Fwd_Data2, 8'h42);
      EX_WB_RegWrite = 1'b0;
      #1;
      check("nofwd_sel1", Fwd_Sel1, 1'b0);
      check("nofwd_sel2", Fwd_Sel2, 1'b0);
      check("nofwd_data1", Fwd_Data1, 8'h01);
      ID_EX_Src2_Num = 3'd4;
      EX_WB_RegWrite = 1'b1;
      #1;
      check("fwd_sel2_hit", Fwd_Sel2, 1'b1);
      check("fwd_data2_hit", Fwd_Data2, 8'h9E);
      EX_WB_RegWrite = 1'b0;

      // back-to-back writes to r7
      @(negedge Clk);
      EX_WB_RegWrite = 1'b1; EX_WB_Write_Reg_Num = 3'd7; EX_WB_Write_Data = 8'h10;
      @(negedge Clk);
      EX_WB_Write_Data = 8'h20;
      @(negedge Clk);
      EX_WB_RegWrite = 1'b0; Read_Reg_Num1 = 3'd7;
      #1;
      check("b2b_last_wins", Read_Data1, 8'h20);
      check("b2b_cnt", Commit_Count, 16'h0005);

      // counter wrap from a clean reset
      Reset = 1'b0;
      #1;
      Reset = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         @(negedge Clk);
         if ((i % 8192) == 0 && i != 0) begin
            EX_WB_RegWrite = 1'b0;
            @(posedge Clk); #1;
            check("idle_hold", Commit_Count, i[15:0]);
            @(negedge Clk);
         end
         EX_WB_RegWrite = 1'b1;
         EX_WB_Write_Reg_Num = i[2:0];
         EX_WB_Write_Data = i[7:0];
         if (i == 65535) begin
            #1;
            check("cnt_allones", Commit_Count, 16'hFFFF);
         end
      end
      @(negedge Clk);
      EX_WB_RegWrite = 1'b0;
      Read_Reg_Num1 = 3'd7; Read_Reg_Num2 = 3'd0;
      #1;
      check("cnt_wrap", Commit_Count, 16'h0000);
      check("wrap_r7", Read_Data1, 8'hFF);
      check("wrap_r0", Read_Data2, 8'hF8);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
